// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM over the instruction phases that drives the
// datapath muxes and write enables, with a Funct-driven ALUControl in R-type execute.
module mips_mc_controller #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    output logic [2:0]         ALUControl,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSrc,
    output logic               IorD,
    output logic               IRWrite,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               PCEn,
    output logic               IllegalOp,
    output logic [STATE_W-1:0] State
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = STATE_W'(0),
        S_DECODE  = STATE_W'(1),
        S_MEMADR  = STATE_W'(2),
        S_MEMRD   = STATE_W'(3),
        S_MEMWB   = STATE_W'(4),
        S_MEMWR   = STATE_W'(5),
        S_RTYPEEX = STATE_W'(6),
        S_RTYPEWB = STATE_W'(7),
        S_BEQEX   = STATE_W'(8),
        S_ITYPEEX = STATE_W'(9),
        S_ITYPEWB = STATE_W'(10),
        S_JEX     = STATE_W'(11)
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_funct_ok;
    logic [2:0] w_rt_aluctrl;
    logic [1:0] w_rt_srca;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_regwrite;
    logic       w_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // R-type function decode; shifts take their amount from the shamt field
    always_comb begin
        w_funct_ok   = 1'b1;
        w_rt_aluctrl = 3'd0;
        w_rt_srca    = 2'd1;
        case (Funct)
            6'b100000: w_rt_aluctrl = 3'd2;
            6'b100010: w_rt_aluctrl = 3'd3;
            6'b100100: w_rt_aluctrl = 3'd0;
            6'b100101: w_rt_aluctrl = 3'd1;
            6'b101010: w_rt_aluctrl = 3'd6;
            6'b000000: begin
                w_rt_aluctrl = 3'd4;
                w_rt_srca    = 2'd2;
            end
            6'b000010: begin
                w_rt_aluctrl = 3'd5;
                w_rt_srca    = 2'd2;
            end
            default: begin
                w_funct_ok = 1'b0;
                w_rt_srca  = 2'd0;
            end
        endcase
    end

    always_comb begin
        w_next     = S_FETCH;
        ALUControl = 3'd0;
        ALUSrcA    = 2'd0;
        ALUSrcB    = 2'd0;
        PCSrc      = 2'd0;
        IorD       = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_irwrite  = 1'b1;
                ALUSrcB    = 2'd1;
                ALUControl = 3'd2;
                w_pcwrite  = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB    = 2'd3;
                ALUControl = 3'd2;
                case (Op)
                    OP_LW, OP_SW:    w_next = S_MEMADR;
                    OP_RTYPE: begin
                        if (w_funct_ok) begin
                            w_next = S_RTYPEEX;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    OP_BEQ:          w_next = S_BEQEX;
                    OP_ADDI, OP_LUI: w_next = S_ITYPEEX;
                    OP_J:            w_next = S_JEX;
                    default:         w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'd1;
                ALUSrcB    = 2'd2;
                ALUControl = 3'd2;
                w_next     = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD   = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                w_memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                ALUControl = w_rt_aluctrl;
                ALUSrcA    = w_rt_srca;
                w_next     = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                RegDst     = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BEQEX: begin
                ALUSrcA    = 2'd1;
                ALUControl = 3'd3;
                PCSrc      = 2'd1;
                w_branch   = 1'b1;
            end
            S_ITYPEEX: begin
                ALUSrcB = 2'd2;
                if (Op == OP_LUI) begin
                    ALUControl = 3'd7;
                end else begin
                    ALUSrcA    = 2'd1;
                    ALUControl = 3'd2;
                end
                w_next = S_ITYPEWB;
            end
            S_ITYPEWB: w_regwrite = 1'b1;
            S_JEX: begin
                PCSrc     = 2'd2;
                w_pcwrite = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Write enables are masked during reset since reset parks the FSM in FETCH
    assign IRWrite   = w_irwrite  & ~reset;
    assign MemWrite  = w_memwrite & ~reset;
    assign RegWrite  = w_regwrite & ~reset;
    assign IllegalOp = w_illegal  & ~reset;
    assign PCEn      = (w_pcwrite | (w_branch & Zero)) & ~reset;
    assign State     = r_state;

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
Multicycle MIPS control unit that drives the shared 32-bit ALU's 3-bit ALUControl port and the multicycle datapath's muxes and write enables. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback. ALUControl is a Mealy output on Funct in the R-type execute state only. Sits between the instruction register (Op/Funct) and the datapath, and consumes the ALU Zero flag for branches.

Parameters:
STATE_W, 4, width of the state register and State debug port

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces FETCH state
Op  input  6  opcode from the instruction register, Instr[31:26]
Funct  input  6  function field from the instruction register, Instr[5:0]
Zero  input  1  ALU result == 0, from the datapath
ALUControl  output  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SrcB<<SrcA[5:0], 5 SrcB>>SrcA[5:0], 6 SLT, 7 SrcB<<16
ALUSrcA  output  2  0 PC, 1 register A, 2 zero-extended shamt
ALUSrcB  output  2  0 register B, 1 constant 4, 2 SignImm, 3 SignImm<<2
PCSrc  output  2  0 ALUResult, 1 ALUOut, 2 jump target
IorD  output  1  memory address select: 0 PC, 1 ALUOut
IRWrite  output  1  instruction register load
MemWrite  output  1  data memory write
RegWrite  output  1  register file write
RegDst  output  1  write register select: 0 rt, 1 rd
MemtoReg  output  1  writeback select: 0 ALUOut, 1 memory data
PCEn  output  1  PC load = PCWrite | (Branch & Zero)
IllegalOp  output  1  one-cycle pulse in DECODE for an unsupported Op/Funct
State  output  STATE_W  current state, debug only

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high. Reset forces the state to FETCH immediately.
- While reset is high, force IRWrite, MemWrite, RegWrite, PCEn and IllegalOp to 0. All other outputs take their FETCH values.
- Default for every output in every state is 0 unless the state lists it.
- States and encodings:
  - FETCH 0: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUControl=2, PCSrc=0, PCWrite=1. Next state DECODE.
  - DECODE 1: ALUSrcA=0, ALUSrcB=3, ALUControl=2 (branch target to ALUOut). Next state by Op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) with a supported Funct -> RTYPEEX
    - 000100 (beq) -> BEQEX
    - 001000 (addi) or 001111 (lui) -> ITYPEEX
    - 000010 (j) -> JEX
    - anything else -> FETCH with IllegalOp=1 for this cycle. No state is written; execution continues at PC+4.
  - MEMADR 2: ALUSrcA=1, ALUSrcB=2, ALUControl=2. Next MEMRD for lw, MEMWR for sw.
  - MEMRD 3: IorD=1. Next MEMWB.
  - MEMWB 4: RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH.
  - MEMWR 5: IorD=1, MemWrite=1. Next FETCH.
  - RTYPEEX 6: ALUSrcB=0. Next RTYPEWB. ALUControl and ALUSrcA decode from Funct:
    - 100000 -> ALUControl 2, ALUSrcA 1
    - 100010 -> ALUControl 3, ALUSrcA 1
    - 100100 -> ALUControl 0, ALUSrcA 1
    - 100101 -> ALUControl 1, ALUSrcA 1
    - 101010 -> ALUControl 6, ALUSrcA 1
    - 000000 (sll) -> ALUControl 4, ALUSrcA 2
    - 000010 (srl) -> ALUControl 5, ALUSrcA 2
  - RTYPEWB 7: RegDst=1, MemtoReg=0, RegWrite=1. Next FETCH.
  - BEQEX 8: ALUSrcA=1, ALUSrcB=0, ALUControl=3, PCSrc=1, Branch=1. PCEn=Zero. Next FETCH.
  - ITYPEEX 9: ALUSrcB=2. addi: ALUSrcA=1, ALUControl=2. lui: ALUControl=7. Next ITYPEWB.
  - ITYPEWB 10: RegDst=0, MemtoReg=0, RegWrite=1. Next FETCH.
  - JEX 11: PCSrc=2, PCWrite=1. Next FETCH.
- Unused encodings 12-15 go to FETCH on the next edge, with all outputs at default.
- Latency in cycles:
  - lw 5
  - sw, R-type, addi, lui 4
  - beq, j 3
  - illegal 2
- Op and Funct are held stable by the instruction register after FETCH. The controller never latches them.
- Reset asserted mid-instruction abandons the instruction. No write enable may be high in the cycle after reset is released, except FETCH's IRWrite/PCEn.

Test Plan:
- Hold reset high: State=0 and IRWrite=PCEn=RegWrite=MemWrite=0. Release reset: next cycle IRWrite=1, PCEn=1, ALUSrcB=1, ALUControl=2.
- Op=100011 from reset: State sequence 0,1,2,3,4,0. MEMRD has IorD=1; MEMWB has RegWrite=1 and MemtoReg=1; PCEn=1 only in FETCH.
- Op=000000: Funct=000010 gives RTYPEEX with ALUControl=5, ALUSrcA=2. Funct=101010 gives ALUControl=6, ALUSrcA=1. RTYPEWB has RegDst=1, RegWrite=1.
- Op=000100: with Zero=1, BEQEX has PCEn=1 and PCSrc=1. With Zero=0, PCEn=0. Both return to FETCH after 3 cycles.
- Op=001111 gives ITYPEEX with ALUControl=7 and ALUSrcB=2, then ITYPEWB with RegWrite=1, RegDst=0.
- Op=111111 gives IllegalOp=1 for exactly one cycle in DECODE, then FETCH. Reset asserted in MEMWR forces State=0 asynchronously, with MemWrite=0 in the same cycle.
